// File: rtl/rot_tile_sequencer.sv
// Tile-walking DMA command sequencer for the rotate path: reads a 4x4 source
// tile row by row, waits for the rotate core, then writes the tile to its rotated origin.
module rot_tile_sequencer #(
    parameter int TILE  = 4,
    parameter int DIM_W = 11
) (
    input  logic             I_HCLK,
    input  logic             I_HRESET_N,
    input  logic             I_GO,
    input  logic [31:0]      I_SRC_ADDR,
    input  logic [31:0]      I_DST_ADDR,
    input  logic [DIM_W-1:0] I_WIDTH,
    input  logic [DIM_W-1:0] I_HEIGHT,
    input  logic [1:0]       I_DIR,
    input  logic             I_DMA_READY,
    input  logic             I_TILE_ROT_DONE,
    output logic             O_DMA_START,
    output logic [31:0]      O_DMA_ADDR,
    output logic             O_DMA_SIZE,
    output logic [4:0]       O_DMA_COUNT,
    output logic             O_DMA_WRITE,
    output logic             O_TILE_LOADED,
    output logic             O_BUSY,
    output logic             O_DONE,
    output logic             O_ERR
);
    typedef enum logic [2:0] {
        S_IDLE, S_RD_ISSUE, S_RD_WAIT, S_CORE_WAIT,
        S_WR_ISSUE, S_WR_WAIT, S_NEXT, S_DONE
    } state_t;

    localparam logic [DIM_W-1:0] TSZ = DIM_W'(TILE);
    localparam int IW = 2*DIM_W + 1;

    state_t           state_q, state_d;
    logic [31:0]      src_q, src_d, dst_q, dst_d;
    logic [DIM_W-1:0] w_q, w_d, h_q, h_d, x_q, x_d, y_q, y_d;
    logic [1:0]       dir_q, dir_d, r_q, r_d;
    logic             seen_low_q, seen_low_d;
    logic             start_q, start_d, size_q, size_d, write_q, write_d;
    logic [31:0]      addr_q, addr_d;
    logic [4:0]       count_q, count_d;
    logic             tl_q, tl_d, busy_q, busy_d, done_q, done_d, err_q, err_d;

    logic             wr_sel, go_bad;
    logic [DIM_W-1:0] dx0, dy0, pitch, row, col, r_ext;
    logic [IW-1:0]    idx;
    logic [31:0]      addr_calc;

    // One shared index datapath: source raster in read states, rotated origin in write states.
    always_comb begin
        r_ext  = DIM_W'(r_q);
        wr_sel = (state_q == S_WR_ISSUE);
        case (dir_q)
            2'd0:    begin dx0 = h_q - TSZ - y_q; dy0 = x_q;             end
            2'd1:    begin dx0 = y_q;             dy0 = w_q - TSZ - x_q; end
            default: begin dx0 = w_q - TSZ - x_q; dy0 = h_q - TSZ - y_q; end
        endcase
        pitch     = (wr_sel && dir_q != 2'd2) ? h_q : w_q;
        row       = wr_sel ? dy0 + r_ext : y_q + r_ext;
        col       = wr_sel ? dx0 : x_q;
        idx       = IW'(row) * IW'(pitch) + IW'(col);
        addr_calc = (wr_sel ? dst_q : src_q) + 32'({idx, 2'b00});
    end

    assign go_bad = (I_WIDTH == '0) || (I_HEIGHT == '0) || (I_WIDTH[1:0] != 2'b00) ||
                    (I_HEIGHT[1:0] != 2'b00) || (I_DIR == 2'd3);

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        dst_d      = dst_q;
        w_d        = w_q;
        h_d        = h_q;
        dir_d      = dir_q;
        x_d        = x_q;
        y_d        = y_q;
        r_d        = r_q;
        seen_low_d = seen_low_q;
        start_d    = 1'b0;
        addr_d     = addr_q;
        size_d     = size_q;
        count_d    = count_q;
        write_d    = write_q;
        tl_d       = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            S_IDLE: if (I_GO) begin
                if (go_bad) begin
                    err_d = 1'b1;
                end else begin
                    src_d   = I_SRC_ADDR;
                    dst_d   = I_DST_ADDR;
                    w_d     = I_WIDTH;
                    h_d     = I_HEIGHT;
                    dir_d   = I_DIR;
                    x_d     = '0;
                    y_d     = '0;
                    r_d     = 2'd0;
                    busy_d  = 1'b1;
                    state_d = S_RD_ISSUE;
                end
            end
            S_RD_ISSUE, S_WR_ISSUE: if (I_DMA_READY) begin
                start_d    = 1'b1;
                addr_d     = addr_calc;
                write_d    = wr_sel;
                size_d     = 1'b1;
                count_d    = 5'(TILE);
                seen_low_d = 1'b0;
                state_d    = wr_sel ? S_WR_WAIT : S_RD_WAIT;
            end
            // Ready is still high in the START cycle; completion is a low-then-high.
            S_RD_WAIT, S_WR_WAIT: begin
                if (!I_DMA_READY) begin
                    seen_low_d = 1'b1;
                end else if (seen_low_q) begin
                    if (r_q != 2'd3) begin
                        r_d     = r_q + 2'd1;
                        state_d = (state_q == S_WR_WAIT) ? S_WR_ISSUE : S_RD_ISSUE;
                    end else if (state_q == S_RD_WAIT) begin
                        r_d     = 2'd0;
                        tl_d    = 1'b1;
                        state_d = S_CORE_WAIT;
                    end else begin
                        state_d = S_NEXT;
                    end
                end
            end
            S_CORE_WAIT: if (I_TILE_ROT_DONE) state_d = S_WR_ISSUE;
            S_NEXT: begin
                r_d = 2'd0;
                if (x_q + TSZ == w_q) begin
                    x_d     = '0;
                    y_d     = y_q + TSZ;
                    state_d = (y_q + TSZ == h_q) ? S_DONE : S_RD_ISSUE;
                end else begin
                    x_d     = x_q + TSZ;
                    state_d = S_RD_ISSUE;
                end
            end
            S_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge I_HCLK) begin
        if (!I_HRESET_N) begin
            state_q    <= S_IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            w_q        <= '0;
            h_q        <= '0;
            dir_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            r_q        <= '0;
            seen_low_q <= 1'b0;
            start_q    <= 1'b0;
            addr_q     <= '0;
            size_q     <= 1'b0;
            count_q    <= '0;
            write_q    <= 1'b0;
            tl_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            w_q        <= w_d;
            h_q        <= h_d;
            dir_q      <= dir_d;
            x_q        <= x_d;
            y_q        <= y_d;
            r_q        <= r_d;
            seen_low_q <= seen_low_d;
            start_q    <= start_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            count_q    <= count_d;
            write_q    <= write_d;
            tl_q       <= tl_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign O_DMA_START   = start_q;
    assign O_DMA_ADDR    = addr_q;
    assign O_DMA_SIZE    = size_q;
    assign O_DMA_COUNT   = count_q;
    assign O_DMA_WRITE   = write_q;
    assign O_TILE_LOADED = tl_q;
    assign O_BUSY        = busy_q;
    assign O_DONE        = done_q;
    assign O_ERR         = err_q;
endmodule

// File: tb/tb_rot_tile_sequencer.sv
// Directed bench for rot_tile_sequencer with a 3-cycle-busy DMA model and optional auto rotate core.
module tb_rot_tile_sequencer;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0, go = 1'b0;
    logic [31:0] src = '0, dst = '0;
    logic [10:0] w = '0, h = '0;
    logic [1:0]  dir = '0;
    logic        dma_rdy = 1'b0, rot_man = 1'b0, rot_auto = 1'b0;
    logic        hold_low = 1'b0, auto_core = 1'b0;
    logic [1:0]  dma_busy = '0;

    logic        start, size, wr, tl, busy, done, err;
    logic [31:0] addr;
    logic [4:0]  count;

    rot_tile_sequencer #(.TILE(4), .DIM_W(11)) dut (
        .I_HCLK(clk), .I_HRESET_N(rst_n), .I_GO(go),
        .I_SRC_ADDR(src), .I_DST_ADDR(dst), .I_WIDTH(w), .I_HEIGHT(h), .I_DIR(dir),
        .I_DMA_READY(dma_rdy), .I_TILE_ROT_DONE(rot_man | rot_auto),
        .O_DMA_START(start), .O_DMA_ADDR(addr), .O_DMA_SIZE(size), .O_DMA_COUNT(count),
        .O_DMA_WRITE(wr), .O_TILE_LOADED(tl), .O_BUSY(busy), .O_DONE(done), .O_ERR(err)
    );

    logic [31:0] cmd_addr[$];
    logic        cmd_wr[$];
    logic [5:0]  cmd_sc[$];
    int tl_cnt = 0, done_cnt = 0, err_cnt = 0, busy_cyc = 0, start_bad = 0;
    int errors = 0, checks = 0;

    // DMA model: ready drops after each START and stays low for three cycles.
    always @(negedge clk) begin
        if (start) begin
            cmd_addr.push_back(addr);
            cmd_wr.push_back(wr);
            cmd_sc.push_back({size, count});
            if (!dma_rdy) start_bad <= start_bad + 1;
            dma_busy <= 2'd3;
            dma_rdy  <= 1'b0;
        end else begin
            dma_busy <= (dma_busy != 2'd0) ? dma_busy - 2'd1 : 2'd0;
            dma_rdy  <= (dma_busy <= 2'd1) && !hold_low;
        end
        if (tl)   tl_cnt   <= tl_cnt + 1;
        if (done) done_cnt <= done_cnt + 1;
        if (err)  err_cnt  <= err_cnt + 1;
        if (busy) busy_cyc <= busy_cyc + 1;
        rot_auto <= auto_core && tl;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic launch(input logic [31:0] s, input logic [31:0] d,
                          input logic [10:0] ww, input logic [10:0] hh, input logic [1:0] dd);
        src = s; dst = d; w = ww; h = hh; dir = dd;
        go = 1'b1;
        step(1);
        go = 1'b0;
    endtask

    task automatic wait_cmds(input int n, input string tag);
        int k = 0;
        while (cmd_addr.size() < n && k < 2000) begin step(1); k++; end
        chk(tag, 32'(cmd_addr.size() >= n), 32'd1);
    endtask

    task automatic wait_done(input string tag);
        int d0 = done_cnt;
        int k = 0;
        while (done_cnt == d0 && k < 3000) begin step(1); k++; end
        chk(tag, 32'(done_cnt - d0), 32'd1);
    endtask

    task automatic wait_tl(input string tag);
        int t0 = tl_cnt;
        int k = 0;
        while (tl_cnt == t0 && k < 500) begin step(1); k++; end
        chk(tag, 32'(tl_cnt - t0), 32'd1);
    endtask

    initial begin
        int b, e0, bc0, t0;
        logic [31:0] exp_min [8];
        exp_min = '{32'h1000, 32'h1010, 32'h1020, 32'h1030,
                    32'h2000, 32'h2010, 32'h2020, 32'h2030};

        // Reset state
        step(3);
        chk("rst_ctl", 32'({start, size, count, wr, tl, busy, done, err}), 32'd0);
        chk("rst_addr", addr, 32'd0);
        rst_n = 1'b1;
        step(2);

        // Rejected configurations
        b = cmd_addr.size(); e0 = err_cnt; bc0 = busy_cyc;
        launch(32'h1000, 32'h2000, 11'd6, 11'd4, 2'd0);
        step(5);
        chk("err_w6", 32'(err_cnt - e0), 32'd1);
        launch(32'h1000, 32'h2000, 11'd4, 11'd4, 2'd3);
        step(5);
        chk("err_dir3", 32'(err_cnt - e0), 32'd2);
        launch(32'h1000, 32'h2000, 11'd4, 11'd0, 2'd0);
        step(5);
        chk("err_h0", 32'(err_cnt - e0), 32'd3);
        chk("err_pulse_end", 32'(err), 32'd0);
        chk("err_nostart", 32'(cmd_addr.size() - b), 32'd0);
        chk("err_nobusy", 32'(busy_cyc - bc0), 32'd0);

        // Minimal 4x4 CW with ready held low and a stray core pulse during reads
        hold_low = 1'b1;
        step(2);
        b = cmd_addr.size(); t0 = tl_cnt;
        launch(32'h1000, 32'h2000, 11'd4, 11'd4, 2'd0);
        step(20);
        chk("hold_nostart", 32'(cmd_addr.size() - b), 32'd0);
        chk("hold_busy", 32'(busy), 32'd1);
        hold_low = 1'b0;
        wait_cmds(b + 1, "first_rd_timeout");
        step(1);
        rot_man = 1'b1; step(1); rot_man = 1'b0;
        wait_tl("min_tl_timeout");
        step(10);
        chk("min_no_early_wr", 32'(cmd_addr.size() - b), 32'd4);
        rot_man = 1'b1; step(1); rot_man = 1'b0;
        wait_done("min_done_timeout");
        chk("min_ncmd", 32'(cmd_addr.size() - b), 32'd8);
        for (int i = 0; i < 8; i++) begin
            if (cmd_addr.size() > b + i) begin
                chk($sformatf("min_addr%0d", i), cmd_addr[b+i], exp_min[i]);
                chk($sformatf("min_wr%0d", i), 32'(cmd_wr[b+i]), (i < 4) ? 32'd0 : 32'd1);
            end
        end
        chk("min_size_count", 32'(cmd_sc[b]), 32'h24);
        chk("min_tl_once", 32'(tl_cnt - t0), 32'd1);
        chk("min_addr_hold", addr, 32'h2030);
        chk("min_busy_clr", 32'(busy), 32'd0);

        // 8x8 CW, config inputs scrambled right after accept
        auto_core = 1'b1;
        b = cmd_addr.size();
        launch(32'h1000, 32'h0, 11'd8, 11'd8, 2'd0);
        w = 11'd3; h = 11'd5; dir = 2'd3; dst = 32'hdead0000; src = 32'hbeef0000;
        wait_done("cw8_done_timeout");
        chk("cw8_ncmd", 32'(cmd_addr.size() - b), 32'd32);
        if (cmd_addr.size() >= b + 32) begin
            chk("cw8_t00_w0", cmd_addr[b+4], 32'h10);
            chk("cw8_t40_w0", cmd_addr[b+12], 32'h90);
            chk("cw8_t04_w0", cmd_addr[b+20], 32'h0);
            chk("cw8_t44_w0", cmd_addr[b+28], 32'h80);
            chk("cw8_t44_w3", cmd_addr[b+31], 32'he0);
            chk("cw8_t00_r3", cmd_addr[b+3], 32'h1060);
            chk("cw8_t40_r0", cmd_addr[b+8], 32'h1010);
            chk("cw8_t04_r0", cmd_addr[b+16], 32'h1080);
            chk("cw8_t40_wr", 32'(cmd_wr[b+12]), 32'd1);
            chk("cw8_t40_rd", 32'(cmd_wr[b+8]), 32'd0);
        end

        // 8x4 CCW
        b = cmd_addr.size();
        launch(32'h0, 32'h100, 11'd8, 11'd4, 2'd1);
        wait_done("ccw_done_timeout");
        chk("ccw_ncmd", 32'(cmd_addr.size() - b), 32'd16);
        if (cmd_addr.size() >= b + 16) begin
            chk("ccw_t00_w0", cmd_addr[b+4], 32'h140);
            chk("ccw_t00_w3", cmd_addr[b+7], 32'h170);
            chk("ccw_t40_w0", cmd_addr[b+12], 32'h100);
            chk("ccw_t40_w3", cmd_addr[b+15], 32'h130);
        end

        // 8x4 180
        b = cmd_addr.size();
        launch(32'h0, 32'h100, 11'd8, 11'd4, 2'd2);
        wait_done("r180_done_timeout");
        chk("r180_ncmd", 32'(cmd_addr.size() - b), 32'd16);
        if (cmd_addr.size() >= b + 16) begin
            chk("r180_t00_w0", cmd_addr[b+4], 32'h110);
            chk("r180_t00_w1", cmd_addr[b+5], 32'h130);
            chk("r180_t40_w0", cmd_addr[b+12], 32'h100);
            chk("r180_t40_w3", cmd_addr[b+15], 32'h160);
            chk("r180_t40_r1", cmd_addr[b+9], 32'h30);
        end

        // Reset during the first row read of tile 2, then a clean restart
        b = cmd_addr.size();
        launch(32'h4000, 32'h0, 11'd8, 11'd4, 2'd0);
        wait_cmds(b + 9, "abort_reach_tile2");
        rst_n = 1'b0;
        step(1);
        chk("abort_ctl", 32'({start, size, count, wr, tl, busy, done, err}), 32'd0);
        chk("abort_addr", addr, 32'd0);
        step(1);
        rst_n = 1'b1;
        b = cmd_addr.size();
        step(20);
        chk("abort_nostart", 32'(cmd_addr.size() - b), 32'd0);
        launch(32'h4000, 32'h0, 11'd4, 11'd4, 2'd0);
        wait_cmds(b + 1, "restart_timeout");
        if (cmd_addr.size() > b) begin
            chk("restart_addr", cmd_addr[b], 32'h4000);
            chk("restart_rd", 32'(cmd_wr[b]), 32'd0);
        end
        wait_done("restart_done_timeout");
        chk("restart_ncmd", 32'(cmd_addr.size() - b), 32'd8);

        chk("start_when_not_ready", 32'(start_bad), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
